// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: instruction field layout,
// FSM state codes, special opcodes and the instruction decoder.
package alu_seq_pkg;

    localparam int unsigned OPW        = 8;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned FIELD_W    = 4;
    localparam int unsigned OP_HI_LSB  = 12;
    localparam int unsigned RDEST_LSB  = 8;
    localparam int unsigned OP_EXT_LSB = 4;
    localparam int unsigned RSRC_LSB   = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [OPW-1:0] OP_CMP  = 8'h0B;
    localparam logic [OPW-1:0] OP_CMPI = 8'hB0;

    typedef struct packed {
        logic [OPW-1:0]     op_code;
        logic               use_imm;
        logic [INSTR_W-1:0] imm;
        logic               wr;
    } dec_t;

    function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
        dec_t       d;
        logic [3:0] op_hi;
        logic [3:0] op_ext;
        logic [7:0] imm8;
        op_hi  = instr[OP_HI_LSB +: FIELD_W];
        op_ext = instr[OP_EXT_LSB +: FIELD_W];
        imm8   = {op_ext, instr[RSRC_LSB +: FIELD_W]};
        if (op_hi == 4'h0) begin
            d.op_code = {op_hi, op_ext};
            d.use_imm = 1'b0;
            d.imm     = '0;
        end else begin
            d.op_code = {op_hi, 4'h0};
            d.use_imm = 1'b1;
            d.imm     = {{8{imm8[7]}}, imm8};
        end
        // Compares only set flags, so they must never write the register file.
        d.wr = (d.op_code != OP_CMP) && (d.op_code != OP_CMPI);
        return d;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; a push while full is dropped even if a pop
// happens in the same cycle, since fullness comes from the registered count.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Programmable issue controller: buffers instruction words and drives the
// register-file/ALU controls through an EXEC then WB phase per instruction.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        step_en,
    input  logic        step,
    output logic [15:0] regEnable,
    output logic [3:0]  a_select,
    output logic [3:0]  b_select,
    output logic        use_imm,
    output logic [15:0] immediate,
    output logic [7:0]  opCode,
    output logic        busy,
    output logic [15:0] issued_count
);

    logic [1:0]            state_q, state_d;
    logic [15:0]           ir_q, ir_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  step_prev_q;
    logic                  step_pend_q, step_pend_d;
    logic                  fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [15:0]           fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  go, step_rise;
    dec_t                  dec;

    assign fifo_push = in_valid && in_ready;
    assign in_ready  = !fifo_full;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (in_instr),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign step_rise = step && !step_prev_q;
    assign go        = !fifo_empty && (!step_en || step_pend_q);

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    fifo_pop = 1'b1;
                    ir_d     = fifo_head;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                cnt_d = cnt_q + 16'd1;
                // Chain straight into the next EXEC to sustain one issue per two cycles.
                if (go) begin
                    fifo_pop = 1'b1;
                    ir_d     = fifo_head;
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A rise landing in a pop cycle is kept for the following instruction.
    always_comb begin
        step_pend_d = step_pend_q;
        if (!step_en) begin
            step_pend_d = 1'b0;
        end else if (step_rise) begin
            step_pend_d = 1'b1;
        end else if (fifo_pop) begin
            step_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            cnt_q       <= '0;
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            step_prev_q <= step;
            step_pend_q <= step_pend_d;
        end
    end

    assign dec          = decode(ir_q);
    assign a_select     = ir_q[RDEST_LSB +: FIELD_W];
    assign b_select     = ir_q[RSRC_LSB +: FIELD_W];
    assign opCode       = dec.op_code;
    assign use_imm      = dec.use_imm;
    assign immediate    = dec.imm;
    assign regEnable    = (state_q == ST_WB && dec.wr) ? (16'd1 << a_select) : 16'd0;
    assign busy         = (fifo_count != '0) || (state_q != ST_IDLE);
    assign issued_count = cnt_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue controller for the register-file/ALU datapath; the programmable replacement for the hard-wired Fibonacci FSM.
- Accepts 16-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each word and drives regEnable, a_select, b_select, use_imm, immediate and opCode in a two-phase EXEC/WB sequence.
- Optional single-step mode lets a board button advance one instruction at a time.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_instr  in  16  instruction word
- in_valid  in  1  in_instr valid this cycle
- in_ready  out  1  FIFO can accept a word
- step_en  in  1  1 = single-step mode
- step  in  1  debounced step button level
- regEnable  out  16  one-hot register write enable
- a_select  out  4  register read A (Rdest)
- b_select  out  4  register read B (Rsrc)
- use_imm  out  1  select immediate for ALU B
- immediate  out  16  sign-extended imm8
- opCode  out  8  ALU opcode
- busy  out  1  FIFO non-empty or state ≠ IDLE
- issued_count  out  16  completed instructions

Behaviour:
- Instruction fields:
  - [15:12] op_hi, [11:8] rdest, [7:4] op_ext, [3:0] rsrc.
  - op_hi = 0: register form. opCode = {op_hi, op_ext}, use_imm = 0.
  - op_hi ≠ 0: immediate form. opCode = {op_hi, 4'h0}, use_imm = 1, immediate = sign-extended {op_ext, rsrc}.
  - a_select = rdest, b_select = rsrc (b_select is don't-care-but-driven in immediate form).
- No-write ops: OP_CMP = 8'h0B and OP_CMPI = 8'hB0 never assert regEnable.
- FIFO:
  - in_ready = !full, taken from the registered count only. A push while full is ignored even if a pop occurs in the same cycle.
  - Push happens when in_valid && in_ready.
  - Simultaneous push and pop is legal when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Issue permission (go):
  - step_en = 0: go = FIFO non-empty.
  - step_en = 1: go = FIFO non-empty && step_pending.
  - step_pending sets on a rising edge of step (one registered previous sample) and clears on pop.
  - step_pending is forced to 0 while step_en = 0.
  - A rising edge arriving during a pop cycle sets step_pending for the next instruction.
- State machine, states IDLE, EXEC, WB:
  - IDLE: go → pop head into instruction register, next state EXEC. Otherwise stay in IDLE.
  - EXEC: controls driven from the instruction register, regEnable = 0 (ALU settles). Next state WB unconditionally.
  - WB: same controls, regEnable = 1 << rdest unless no-write op. On exit, issued_count += 1 (wraps FFFF→0000). go → pop and next state EXEC (back-to-back); else IDLE.
- Control outputs are combinational from the instruction register and state. regEnable is 0 outside WB. In IDLE, the other outputs hold the last instruction's values.
- Latency and throughput:
  - A word accepted at edge T with the FIFO empty reaches EXEC in cycle T+1 and WB in T+2; regEnable pulses for exactly one cycle.
  - Sustained throughput is 1 instruction per 2 cycles.
- Reset (rst = 0 at any time, including mid-instruction):
  - FIFO emptied, state IDLE, instruction register 0, step_pending 0, issued_count 0.
  - Outputs: regEnable 0, a_select 0, b_select 0, use_imm 0, immediate 0, opCode 0, busy 0, in_ready 1.
  - An in-flight WB is aborted: no write, no count.

Decomposition:
- alu_seq_pkg holds:
  - state enum
  - field bit positions
  - OP_CMP / OP_CMPI constants
  - opcode width (8)
  - decode function returning {opCode, use_imm, immediate, wr}
- Sub-module instr_fifo: synchronous FIFO, 16-bit data, parameter DEPTH, with push/pop/full/empty/count, async active-low reset.

Test Plan:
- Reset, then push 16'h0153 (reg form, op_ext 5, rd 1, rs 3) → EXEC: a_select 1, b_select 3, opCode 8'h05, use_imm 0, regEnable 0. WB: regEnable 16'h0002. issued_count 1.
- Push 16'h52F6 → opCode 8'h50, use_imm 1, immediate 16'hFFF6, regEnable 16'h0004 in WB. Push 16'h5A7F → immediate 16'h007F.
- Push 16'h00BC (CMP) and 16'hB302 (CMPI) → regEnable stays 0 through both WB cycles; issued_count still increments, by 2.
- Hold in_valid high with DEPTH=4 and 6 distinct words, no pops (step_en = 1, no step) → exactly 4 accepted, in_ready 0. Then 4 step edges → 4 issues in order. Without extra steps the sequencer stays in IDLE with busy 0.
- Back-to-back: fill 3 words with step_en = 0 → regEnable pulses at cycles 2, 4, 6 after first acceptance; no IDLE cycle between instructions.
- Assert rst during WB of word 2 of 3 → regEnable drops to 0 immediately. After release: busy 0, issued_count 0, FIFO empty, in_ready 1.
